dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between NREQ requesters (req 0 = pipeline MEM stage,
//  req 1 = debug/loader port). Per-cycle arbitration drives memory A/WD/WE and returns

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arb_if.sv | 28 ++
 rtl/dmem_arb_rr_picker.sv | 30 +++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned MEM_ADDR_BITS = 8;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/dmem_arb_if.sv
// Requester-side bus of the data-memory arbiter; one lane per requester.
interface dmem_arb_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
);

  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             lock;
  logic [NREQ-1:0]             we;
  logic [NREQ-1:0][DATA_W-1:0] addr;
  logic [NREQ-1:0][DATA_W-1:0] wdata;
  logic [NREQ-1:0]             gnt;
  logic [NREQ-1:0]             rvalid;
  logic [DATA_W-1:0]           rdata;
  logic                        err;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/dmem_arb_rr_picker.sv
// Round-robin picker: first requesting index at or after ptr_i, wrapping at NREQ.
module rr_picker #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] win_oh_o,
  output logic [IW-1:0]   win_idx_o,
  output logic            valid_o
);

  logic [IW-1:0] idx;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    valid_o   = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IW'((32'(ptr_i) + k) % NREQ);
      if (!valid_o && req_i[idx]) begin
        win_oh_o[idx] = 1'b1;
        win_idx_o     = idx;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter with locked RMW, range check and registered response.
// DMEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned ADDR_BITS = MEM_ADDR_BITS
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arb_if.slave         bus_io,
  output logic [DATA_W-1:0] mem_a_o,
  output logic [DATA_W-1:0] mem_wd_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rd_i
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     w_idx;
  logic [IW-1:0]     pick_idx;
  logic [NREQ-1:0]   pick_oh;
  logic              pick_valid;
  logic [NREQ-1:0]   gnt_c;
  logic              gnt_any;
  logic              in_range;
  mem_cmd_t          cmd;
  logic [NREQ-1:0]   rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Lowest requesting index wins; scan downwards so the last hit is the lowest.
  always_comb begin
    pick_oh    = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (bus_io.req[IW'(i)]) begin
        pick_oh           = '0;
        pick_oh[IW'(i)]   = 1'b1;
        pick_idx          = IW'(i);
        pick_valid        = 1'b1;
      end
    end
  end
`else
  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req_i     (bus_io.req),
    .ptr_i     (rr_ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .valid_o   (pick_valid)
  );
`endif

  // Grant selection and lock tracking.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    gnt_c    = '0;
    w_idx    = owner_q;
    case (state_q)
      ARB: begin
        if (pick_valid) begin
          gnt_c = pick_oh;
          w_idx = pick_idx;
          if (bus_io.lock[pick_idx]) begin
            state_d = LOCKED;
            owner_d = pick_idx;
          end
        end
      end
      LOCKED: begin
        if (bus_io.req[owner_q]) begin
          gnt_c[owner_q] = 1'b1;
          w_idx          = owner_q;
          if (!bus_io.lock[owner_q]) begin
            state_d = ARB;
          end
        end
      end
      default: state_d = ARB;
    endcase
`ifdef DMEM_ARB_FIXED_PRIO_EN
    rr_ptr_d = '0;
`else
    if (|gnt_c) begin
      rr_ptr_d = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
    end
`endif
  end

  assign gnt_any   = |gnt_c;
  assign cmd.we    = bus_io.we[w_idx];
  assign cmd.addr  = bus_io.addr[w_idx];
  assign cmd.wdata = bus_io.wdata[w_idx];
  assign in_range  = (cmd.addr[DATA_W-1:ADDR_BITS] == '0);

  assign mem_a_o  = gnt_any ? cmd.addr  : '0;
  assign mem_wd_o = gnt_any ? cmd.wdata : '0;
  assign mem_we_o = gnt_any & cmd.we & in_range;

  // FSM state plus the one-cycle response stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      rvalid_q <= gnt_c;
      rdata_q  <= (gnt_any && !cmd.we && in_range) ? mem_rd_i : '0;
      err_q    <= gnt_any & ~in_range;
    end
  end

  assign bus_io.gnt    = gnt_c;
  assign bus_io.rvalid = rvalid_q;
  assign bus_io.rdata  = rdata_q;
  assign bus_io.err    = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter with a 256-word memory model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned NREQ = 2;

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  we;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [1:0]  gnt;
    logic        mwe;
    logic [31:0] ma;
    logic [1:0]  rv;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;
  logic [31:0] mem [256] = '{default: '0};
  int          n_cmp = 0;
  int          n_err = 0;
  vec_t        vt[$];

  always #5 clk = ~clk;

  dmem_arb_if #(.NREQ(NREQ)) bus ();

  assign mem_rd = mem[mem_a[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_wd;

  dmem_arbiter #(
    .NREQ      (NREQ),
    .ADDR_BITS (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_io   (bus),
    .mem_a_o  (mem_a),
    .mem_wd_o (mem_wd),
    .mem_we_o (mem_we),
    .mem_rd_i (mem_rd)
  );

  function automatic vec_t mk(
    input logic r, input logic [1:0] rq, input logic [1:0] lk, input logic [1:0] w,
    input logic [31:0] a0, input logic [31:0] d0, input logic [31:0] a1, input logic [31:0] d1,
    input logic [1:0] g, input logic mw, input logic [31:0] ma,
    input logic [1:0] rv, input logic [31:0] rd, input logic er);
    vec_t v;
    v.rst = r;  v.req = rq; v.lock = lk; v.we = w;
    v.a0 = a0;  v.d0 = d0;  v.a1 = a1;   v.d1 = d1;
    v.gnt = g;  v.mwe = mw; v.ma = ma;
    v.rv = rv;  v.rd = rd;  v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // One cycle: drive, check combinational grant side, then the registered response.
  task automatic run(input vec_t v, input string tag);
    rst           = v.rst;
    bus.req       = v.req;
    bus.lock      = v.lock;
    bus.we        = v.we;
    bus.addr[0]   = v.a0;
    bus.addr[1]   = v.a1;
    bus.wdata[0]  = v.d0;
    bus.wdata[1]  = v.d1;
    #2;
    chk({tag, " gnt"},    32'(bus.gnt), 32'(v.gnt));
    chk({tag, " mem_we"}, 32'(mem_we),  32'(v.mwe));
    chk({tag, " mem_a"},  mem_a,        v.ma);
    @(posedge clk);
    #1;
    chk({tag, " rvalid"}, 32'(bus.rvalid), 32'(v.rv));
    chk({tag, " rdata"},  bus.rdata,       v.rd);
    chk({tag, " err"},    32'(bus.err),    32'(v.er));
  endtask

  initial begin
    rst       = 1'b1;
    bus.req   = '0;
    bus.lock  = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset gnt",    32'(bus.gnt),    32'h0);
    chk("reset rvalid", 32'(bus.rvalid), 32'h0);
    chk("reset rdata",  bus.rdata,       32'h0);
    chk("reset err",    32'(bus.err),    32'h0);

    //          rst req    lock   we     a0         d0           a1           d1           gnt    mwe ma           rv     rd            er
    vt.push_back(mk(0, 2'b01, 2'b00, 2'b01, 32'h2,     32'h55,      32'h0,       32'h0,       2'b01, 1, 32'h2,       2'b01, 32'h0,        0));
    vt.push_back(mk(0, 2'b10, 2'b00, 2'b10, 32'h0,     32'h0,       32'h3,       32'hA5A50003, 2'b10, 1, 32'h3,       2'b10, 32'h0,        0));
    vt.push_back(mk(0, 2'b01, 2'b00, 2'b00, 32'h2,     32'h0,       32'h0,       32'h0,       2'b01, 0, 32'h2,       2'b01, 32'h55,       0));
    vt.push_back(mk(1, 2'b00, 2'b00, 2'b00, 32'h0,     32'h0,       32'h0,       32'h0,       2'b00, 0, 32'h0,       2'b00, 32'h0,        0));
`ifdef DMEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(0, 2'b11, 2'b00, 2'b00, 32'h2,   32'h0,       32'h3,       32'h0,       2'b01, 0, 32'h2,       2'b01, 32'h55,       0));
`else
    for (int i = 0; i < 2; i++) begin
      vt.push_back(mk(0, 2'b11, 2'b00, 2'b00, 32'h2,   32'h0,       32'h3,       32'h0,       2'b01, 0, 32'h2,       2'b01, 32'h55,       0));
      vt.push_back(mk(0, 2'b11, 2'b00, 2'b00, 32'h2,   32'h0,       32'h3,       32'h0,       2'b10, 0, 32'h3,       2'b10, 32'hA5A50003, 0));
    end
`endif
    vt.push_back(mk(0, 2'b01, 2'b00, 2'b01, 32'h100,   32'h1,       32'h0,       32'h0,       2'b01, 0, 32'h100,     2'b01, 32'h0,        1));
    vt.push_back(mk(0, 2'b01, 2'b00, 2'b00, 32'h0,     32'h0,       32'h0,       32'h0,       2'b01, 0, 32'h0,       2'b01, 32'h0,        0));
    vt.push_back(mk(0, 2'b01, 2'b00, 2'b01, 32'h5,     32'hDEADBEEF, 32'h0,      32'h0,       2'b01, 1, 32'h5,       2'b01, 32'h0,        0));
    vt.push_back(mk(0, 2'b01, 2'b00, 2'b00, 32'h5,     32'h0,       32'h0,       32'h0,       2'b01, 0, 32'h5,       2'b01, 32'hDEADBEEF, 0));
    vt.push_back(mk(0, 2'b10, 2'b00, 2'b00, 32'h0,     32'h0,       32'h80000004, 32'h0,      2'b10, 0, 32'h80000004, 2'b10, 32'h0,       1));
    vt.push_back(mk(0, 2'b01, 2'b00, 2'b01, 32'h2,     32'h66,      32'h0,       32'h0,       2'b01, 1, 32'h2,       2'b01, 32'h0,        0));
    vt.push_back(mk(0, 2'b01, 2'b00, 2'b01, 32'hFF,    32'h7,       32'h0,       32'h0,       2'b01, 1, 32'hFF,      2'b01, 32'h0,        0));
    foreach (vt[i]) run(vt[i], $sformatf("vec%0d", i));

    // Locked read-modify-write by requester 1 stalls requester 0 until unlock.
    run(mk(1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0,  2'b00, 0, 32'h0, 2'b00, 32'h0,  0), "lock rst");
    run(mk(0, 2'b10, 2'b10, 2'b00, 32'h0, 32'h0, 32'h7, 32'h0,  2'b10, 0, 32'h7, 2'b10, 32'h0,  0), "lock rd");
    run(mk(0, 2'b01, 2'b00, 2'b00, 32'h2, 32'h0, 32'h7, 32'h0,  2'b00, 0, 32'h0, 2'b00, 32'h0,  0), "lock stall");
    run(mk(0, 2'b11, 2'b00, 2'b10, 32'h2, 32'h0, 32'h7, 32'h77, 2'b10, 1, 32'h7, 2'b10, 32'h0,  0), "lock wr");
    run(mk(0, 2'b01, 2'b00, 2'b00, 32'h2, 32'h0, 32'h7, 32'h0,  2'b01, 0, 32'h2, 2'b01, 32'h66, 0), "unlock r0");
    run(mk(0, 2'b01, 2'b00, 2'b00, 32'h7, 32'h0, 32'h0, 32'h0,  2'b01, 0, 32'h7, 2'b01, 32'h77, 0), "rmw check");

    // Reset while a locked read is in flight: response dropped, pointer and lock cleared.
    run(mk(1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 0, 32'h0, 2'b00, 32'h0,        0), "mid rst0");
    run(mk(0, 2'b01, 2'b01, 2'b00, 32'h2, 32'h0, 32'h0, 32'h0, 2'b01, 0, 32'h2, 2'b01, 32'h66,       0), "mid lock");
    run(mk(1, 2'b01, 2'b01, 2'b00, 32'h2, 32'h0, 32'h0, 32'h0, 2'b01, 0, 32'h2, 2'b00, 32'h0,        0), "mid rst");
    run(mk(0, 2'b11, 2'b00, 2'b00, 32'h2, 32'h0, 32'h3, 32'h0, 2'b01, 0, 32'h2, 2'b01, 32'h66,       0), "post rst ptr");
    run(mk(0, 2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 32'h3, 32'h0, 2'b10, 0, 32'h3, 2'b10, 32'hA5A50003, 0), "post rst arb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
